// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier.
package mult_pkg;

    // Transaction state: waiting for operands, stepping partial products, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage : mult_pkg

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder: WIDTH-bit sum plus carry-out, one full-adder cell per bit.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Propagate the carry bit by bit from LSB to MSB.
    always_comb begin
        logic carry;
        // NOTE: blocking '=' is intended here; carry is a combinational
        // temporary that each loop iteration must see updated immediately.
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule : ripple_carry_adder

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, one partial
// product per clock, with valid/ready handshakes on both sides.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand skips straight to
// DONE with product 0 (1-cycle latency instead of WIDTH+1).
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t          state;
    mult_state_t          state_next;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   p;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic                 accept;
    logic                 zero_skip;

    // Handshake flags come from the registered state only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = p;
    assign accept    = in_valid && in_ready;

`ifdef MULT_ZERO_SKIP_EN
    assign zero_skip = (a == '0) || (b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // Add the multiplicand into the upper half when the current multiplier LSB is set.
    assign addend = mcand & {WIDTH{p[0]}};

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (p[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode: accept in IDLE, count steps in BUSY, wait for consumer in DONE.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = zero_skip ? DONE : BUSY;
            BUSY:    if (cnt == LAST_CNT) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, shift in one partial product per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath is reset too, so product reads 0 immediately on
        // reset and no partial result from a discarded transaction survives.
        if (!rst_n) begin
            mcand <= '0;
            p     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= a;
                        p     <= zero_skip ? '0 : {{WIDTH{1'b0}}, b};
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    p   <= {cout, sum, p[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH = 4).
module tb_shift_add_multiplier;

    localparam int W = 4;

`ifdef MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = W + 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           busy;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands for one accept edge; returns one cycle after accept (cycle 1).
    task automatic do_accept(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        check({tag, "_in_ready_at_accept"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; checks the stall flags on the way, then latency and product.
    task automatic expect_result(input string tag, input logic [2*W-1:0] exp_prod, input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 20) begin
            check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
            check({tag, "_busy_high"}, 32'(busy), 32'd1);
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_product"}, 32'(product), 32'(exp_prod));
        check({tag, "_in_ready_in_done"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;
        int q[$];
        int exp_v;

        // Reset values while rst_n is held low.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic multiply: 3*5 with out_ready held high.
        out_ready = 1'b1;
        do_accept("basic", 4'd3, 4'd5);
        expect_result("basic", 8'd15, W + 1);
        tick();
        check("basic_idle_in_ready", 32'(in_ready), 32'd1);
        check("basic_idle_out_valid", 32'(out_valid), 32'd0);
        check("basic_idle_busy", 32'(busy), 32'd0);

        // Carry-out path: 15*15.
        do_accept("carry", 4'd15, 4'd15);
        expect_result("carry", 8'hE1, W + 1);
        tick();
        check("carry_idle_in_ready", 32'(in_ready), 32'd1);

        // Output backpressure: hold out_ready low for 10 cycles in DONE.
        out_ready = 1'b0;
        do_accept("bp", 4'd15, 4'd15);
        expect_result("bp", 8'hE1, W + 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_product", 32'(product), 32'hE1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset in the second BUSY cycle: outputs clear before the next clock edge.
        do_accept("rst_mid", 4'd7, 4'd9);
        tick();
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_product", 32'(product), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_accept("after_rst", 4'd2, 4'd6);
        expect_result("after_rst", 8'd12, W + 1);
        tick();

        // Zero operand.
        do_accept("zero", 4'd0, 4'd9);
        expect_result("zero", 8'd0, ZERO_LAT);
        tick();
        check("zero_idle_in_ready", 32'(in_ready), 32'd1);

        // All 256 operand pairs with random in_valid / out_ready; results checked in order.
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 256 && cyc < 20000) begin
            a         = W'(sent >> W);
            b         = W'(sent);
            in_valid  = (sent < 256) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) begin
                q.push_back((sent >> W) * (sent % (1 << W)));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("exh_unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_v = q.pop_front();
                    check("exh_product", 32'(product), 32'(exp_v));
                end
                recv++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("exh_no_timeout", 32'(cyc < 20000), 32'd1);
        check("exh_sent", 32'(sent), 32'd256);
        check("exh_recv", 32'(recv), 32'd256);
        check("exh_queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_add_multiplier

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Multi-cycle unsigned multiplier that consumes the ripple-carry adder as its accumulate datapath. It computes one `WIDTH x WIDTH -> 2*WIDTH` product per transaction using iterative shift-and-add, one partial product per clock. Operands arrive on a valid/ready input handshake and the product leaves on a valid/ready output handshake. It sits between the operand/control stage and the ALU result path, providing a small-area multiply alongside the existing combinational arithmetic, logic and shift units.

## Interface
- `WIDTH`, default 4: operand width in bits, must be ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands `a` and `b` are valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  multiplicand, unsigned.
- `b`  in  WIDTH  multiplier, unsigned.
- `out_valid`  out  1  `product` is valid.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  2*WIDTH  unsigned result `a*b`.
- `busy`  out  1  a transaction is in flight (state BUSY or DONE).

## Operation
- **State machine states:** IDLE, BUSY, DONE.
- **Reset values:** state IDLE, `out_valid` 0, `busy` 0, `product` 0, `in_ready` 1.
- **Internal registers:**
  - `mcand` (WIDTH bits).
  - `P` (2*WIDTH bits); `product` is driven directly from `P`.
  - Iteration counter `cnt`, clog2(WIDTH+1) bits.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`: `mcand` <= `a`, `P` <= {WIDTH'0, `b`}, `cnt` <= 0, go to BUSY.
- **BUSY, one step per cycle:**
  - Adder sums `P[2W-1:W]` + (`mcand` & {WIDTH{`P[0]`}}) with cin = 0, producing `sum` and `cout`.
  - `P` <= {`cout`, `sum`, `P[W-1:1]`}.
  - `cnt` <= `cnt` + 1.
  - When `cnt` == WIDTH-1 (the last step), go to DONE.
- **DONE:**
  - `out_valid` = 1; `P` is held stable.
  - On `out_ready` go to IDLE.
  - `in_ready` = 0, so there is no accept in the same cycle as the output handshake.
- **Output validity:** `product` changes during BUSY and is meaningful only while `out_valid` = 1. Outside DONE it holds the last `P`.
- **Arithmetic:** fully unsigned; the 2*WIDTH result is exact, with no overflow or truncation.
- **Ignored inputs:**
  - `in_valid` outside IDLE is ignored; `a` and `b` are sampled only at the accept edge.
  - `out_ready` outside DONE is ignored.
- **Reset mid-operation:** `rst_n` low in any state immediately forces the reset values. The in-flight transaction is discarded, with no partial output.

## Timing
- Accept in cycle 0. BUSY occupies cycles 1..WIDTH. `out_valid` is first high in cycle WIDTH+1.
- Latency from accept to first `out_valid` is WIDTH+1 cycles.
- With `out_ready` held high, the next accept is possible at cycle WIDTH+2. Minimum initiation interval is WIDTH+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only, so there are no combinational input-to-output paths.
- `busy` = (state != IDLE).

## Configuration
- **Macro:** `MULT_ZERO_SKIP_EN`.
- **Defined:**
  - At accept, if `a` == 0 or `b` == 0, `P` <= 0 and the state goes directly IDLE -> DONE.
  - `out_valid` is high in cycle 1 with `product` = 0.
  - Latency is 1 cycle for zero operands; non-zero operands are unchanged.
- **Undefined:** zero operands take the full WIDTH+1 latency and produce `product` = 0.

## Structure
- **Package `mult_pkg`:** holds the enum typedef `mult_state_t` {IDLE, BUSY, DONE}.
- **Module-local:** `cnt` width is derived from `WIDTH` as a module-local localparam; it is not in the package.
- **Sub-module:** exactly one instance, `ripple_carry_adder #(.WIDTH(WIDTH))`, used as the accumulate adder with `cin` tied to 0. Its `cout` becomes `P[2W-1]`.
- **Remaining logic:** the FSM, `cnt` and `P` shift register stay in this module.

## Test plan
- **Basic multiply:** WIDTH=4, `a`=3, `b`=5, `out_ready`=1 -> `in_ready` low cycles 1–5; `out_valid` high exactly in cycle 5 with `product`=8'd15; IDLE in cycle 6.
- **Carry-out path:** `a`=15, `b`=15 -> `product`=8'hE1 (225) at cycle 5.
- **Output backpressure:** `a`=15, `b`=15 with `out_ready`=0 for 10 cycles after `out_valid` rises -> `out_valid`=1, `product`=8'hE1 and `in_ready`=0 all held stable; `out_ready`=1 -> IDLE and `in_ready`=1 next cycle.
- **Reset mid-operation:** `a`=7, `b`=9, drop `rst_n` in cycle 2 of BUSY -> `out_valid`, `busy` and `product` go to 0 asynchronously, before the next clock edge; after release, `a`=2, `b`=6 gives `product`=12 with normal latency.
- **Zero operand:** `a`=0, `b`=9 -> without macro, `out_valid` in cycle 5 with `product`=0; with `MULT_ZERO_SKIP_EN`, `out_valid` in cycle 1 with `product`=0.
- **Exhaustive:** all 256 operand pairs back-to-back with random `in_valid` and `out_ready` -> every `product` equals `a*b`, in order, with none dropped or duplicated.
